// File: rtl/ro_freq_meter_if.sv
// Host/oscillator-side signal bundle for the ring-oscillator frequency meter.
// master = host/oscillator side, slave = the meter itself.
interface ro_freq_meter_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             ro_out;
    logic             ro_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             ovf;

    modport master (
        output start, ro_out,
        input  ro_en, busy, done, count, ovf
    );

    modport slave (
        input  start, ro_out,
        output ro_en, busy, done, count, ovf
    );
endinterface

// File: rtl/ro_freq_meter.sv
// Gated-window ring-oscillator frequency meter: enable, settle, count
// synchronised rising edges of ro_out over a fixed clk window, report.
module ro_freq_meter #(
    parameter int SETTLE_CYCLES = 4,
    parameter int GATE_CYCLES   = 1024,
    parameter int CNT_W         = 16
) (
    input logic             clk,
    input logic             rst,
    ro_freq_meter_if.slave  bus
);
    localparam int MAX_CYC = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYCLES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] GATE   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       state;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             s1, s2, s3;
    logic             rise;

    // s1/s2 resolve metastability; s3 is the previous synchronised value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.ro_out;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= SETTLE;
                        timer <= SETTLE_LD;
                    end
                end
                SETTLE: begin
                    if (timer == '0) begin
                        state   <= GATE;
                        timer   <= GATE_LD;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                GATE: begin
                    // saturate rather than wrap so an over-range result stays recognisable
                    if (rise) begin
                        if (count_q == '1) ovf_q <= 1'b1;
                        else               count_q <= count_q + 1'b1;
                    end
                    if (timer == '0) state <= DONE;
                    else             timer <= timer - 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ro_en = (state == SETTLE) || (state == GATE);
    assign bus.busy  = (state == SETTLE) || (state == GATE);
    assign bus.done  = (state == DONE);
    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: two instances (wide and narrow counter), directed
// and randomised oscillator patterns against an edge-history reference model.
module tb_ro_freq_meter;
    logic clk;
    logic rst;
    logic ro_src;

    ro_freq_meter_if #(.CNT_W(16)) a_if ();
    ro_freq_meter_if #(.CNT_W(4))  b_if ();

    assign a_if.ro_out = ro_src;
    assign b_if.ro_out = ro_src;

    ro_freq_meter #(.SETTLE_CYCLES(4), .GATE_CYCLES(64), .CNT_W(16)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    ro_freq_meter #(.SETTLE_CYCLES(4), .GATE_CYCLES(128), .CNT_W(4)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    int   cyc = 0;
    int   passed = 0;
    int   failed = 0;
    int   total = 0;
    int   done_a = 0;
    int   done_b = 0;
    int   last_done = 0;
    int   mode = 0;
    int   half = 4;
    logic hist [0:8191];
    logic [31:0] prev_cnt [2];
    logic        prev_ovf [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // edge n is recorded as hist[n]; after edge n, cyc == n
    always @(posedge clk) begin
        cyc <= cyc + 1;
        hist[(cyc + 1) % 8192] <= ro_src;
        if (a_if.done) done_a <= done_a + 1;
        if (b_if.done) done_b <= done_b + 1;
    end

    // oscillator model: 0 stuck low, 1 square wave toggling every 'half' clk, 2 random
    always @(negedge clk) begin
        case (mode)
            1:       if ((cyc % half) == 0) ro_src = ~ro_src;
            2:       ro_src = 1'($urandom_range(0, 1));
            default: ro_src = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [2:0] flags(input int sel);
        if (sel != 0) return {b_if.ro_en, b_if.busy, b_if.done};
        return {a_if.ro_en, a_if.busy, a_if.done};
    endfunction

    function automatic logic [31:0] get_count(input int sel);
        if (sel != 0) return 32'(b_if.count);
        return 32'(a_if.count);
    endfunction

    function automatic logic get_ovf(input int sel);
        if (sel != 0) return b_if.ovf;
        return a_if.ovf;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) b_if.start = v;
        else          a_if.start = v;
    endtask

    // Reference: the meter counts 0->1 transitions of ro_out as sampled by clk,
    // seen two clocks late through the synchroniser, over a G-cycle window that
    // opens S cycles after the start edge k.
    function automatic void model(input int k, input int s, input int g, input int w,
                                  output logic [31:0] c, output logic o);
        int n = 0;
        int lim = (1 << w) - 1;
        for (int j = k + s - 1; j <= k + s + g - 2; j++)
            if (hist[j % 8192] && !hist[(j - 1) % 8192]) n++;
        o = (n > lim);
        c = o ? 32'(lim) : 32'(n);
    endfunction

    // Entered at a negedge with the DUT idle; leaves at the negedge of the
    // IDLE cycle following DONE.
    task automatic run(input int sel, input bit hold, input bit repulse, input bit gap_chk);
        int          k;
        int          s;
        int          g;
        int          w;
        int          dbefore;
        logic [31:0] ec;
        logic        eo;
        s = 4;
        g = (sel != 0) ? 128 : 64;
        w = (sel != 0) ? 4 : 16;
        dbefore = (sel != 0) ? done_b : done_a;
        set_start(sel, 1'b1);
        @(negedge clk);
        k = cyc;
        chk("held_count", get_count(sel), prev_cnt[sel]);
        chk("held_ovf", 32'(get_ovf(sel)), 32'(prev_ovf[sel]));
        for (int c = k; c <= k + s + g; c++) begin
            set_start(sel, hold || (repulse && (c == k + 1 || c == k + s + g / 2)));
            if (c < k + s + g) begin
                chk("busy_flags", 32'(flags(sel)), 32'(3'b110));
            end else begin
                chk("done_flags", 32'(flags(sel)), 32'(3'b001));
                model(k, s, g, w, ec, eo);
                chk("count", get_count(sel), ec);
                chk("ovf", 32'(get_ovf(sel)), 32'(eo));
                prev_cnt[sel] = ec;
                prev_ovf[sel] = eo;
                if (gap_chk) chk("done_gap", 32'(c - last_done), 32'(s + g + 2));
                last_done = c;
            end
            @(negedge clk);
        end
        chk("idle_flags", 32'(flags(sel)), 32'(3'b000));
        chk("one_done", 32'(((sel != 0) ? done_b : done_a) - dbefore), 32'd1);
    endtask

    initial begin
        int dsave;
        rst = 1'b1;
        ro_src = 1'b0;
        a_if.start = 1'b0;
        b_if.start = 1'b0;
        prev_cnt[0] = 0;
        prev_cnt[1] = 0;
        prev_ovf[0] = 1'b0;
        prev_ovf[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_flags_a", 32'(flags(0)), 32'(3'b000));
        chk("rst_count_a", get_count(0), 32'd0);
        chk("rst_ovf_b", 32'(get_ovf(1)), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // square wave, period 8 clk
        mode = 1; half = 4;
        run(0, 1'b0, 1'b0, 1'b0);
        // stuck low
        mode = 0;
        run(0, 1'b0, 1'b0, 1'b0);
        // narrow counter overflows, then a clean run clears it
        mode = 1; half = 2;
        run(1, 1'b0, 1'b0, 1'b0);
        mode = 0;
        run(1, 1'b0, 1'b0, 1'b0);
        // start re-pulsed during SETTLE and GATE
        mode = 1; half = 4;
        run(0, 1'b0, 1'b1, 1'b0);

        // async reset in the middle of GATE
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
        repeat (30) @(negedge clk);
        dsave = done_a;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_flags", 32'(flags(0)), 32'(3'b000));
        chk("rst_mid_count", get_count(0), 32'd0);
        prev_cnt[0] = 0;
        prev_ovf[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        chk("rst_no_done", 32'(done_a - dsave), 32'd0);
        mode = 2;
        run(0, 1'b0, 1'b0, 1'b0);

        // start held high: back-to-back measurements
        mode = 1; half = 3;
        run(0, 1'b1, 1'b0, 1'b0);
        run(0, 1'b1, 1'b0, 1'b1);
        run(0, 1'b0, 1'b0, 1'b1);

        // randomised patterns on both instances
        for (int r = 0; r < 5; r++) begin
            mode = int'($urandom_range(1, 2));
            half = int'($urandom_range(1, 6));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run((r == 2) ? 1 : 0, 1'b0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
